user_input_capture: RTL and testbench
=====================================

# user_input_capture

Input-side companion to the memory-mapped IO block: turns the board switches and the confirm pushbutton into a CPU read with a proper handshake. On a read request the block stalls the processor until the user presses confirm. It then latches the 18 switches, sign-extends them from bit 17 to 32 bits, and pulses a one-cycle valid strobe into the read-data path. It sits between the board pins and the IO register bank, replacing the direct combinational read of the switches.

## Interface
- `DEBOUNCE_CYCLES`, 50000, consecutive stable clock cycles required before a key change is accepted (1 ms at 50 MHz); minimum 2.
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `dadosExternos`  in  18  raw board switches; bit 17 is the sign.
- `confirm_n`  in  1  raw confirm pushbutton, active-low.
- `read_req`  in  1  level; CPU requests a user input value.
- `dadosLidos`  out  32  captured, sign-extended value; held until the next capture.
- `data_valid`  out  1  one-cycle strobe; `dadosLidos` is new this cycle.
- `busy`  out  1  high while the block waits for the user; the CPU stalls on it.
- `echo`  out  32  last captured value for the 7-segment path (see Configuration).

## Operation
- Synchronizers: `confirm_n` (inverted) and `dadosExternos` each pass through a 2-flop synchronizer. All logic below uses the synchronized versions.
- Debouncer:
  - `key_stable` reset value 0.
  - The counter clears whenever `key_sync == key_stable`, and increments otherwise.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the two still differ, `key_stable` toggles and the counter clears.
  - A `press` event is a 0→1 transition of `key_stable`.
- FSM, three states:
  - IDLE: `busy=0`. Go to ARMED when `read_req=1`. `press` events in IDLE are discarded; there is no buffering.
  - ARMED: `busy=1`.
    - `read_req=0` → IDLE (cancel). No strobe is issued and `dadosLidos` is unchanged.
    - `press` with `read_req=1` → latch `{{15{sw[16+1]}}, sw[16:0]}` into `dadosLidos`, set `data_valid=1` for that one cycle, go to RELEASE.
  - RELEASE: `busy=0`. Wait for `key_stable=0`, then go to IDLE.
- Behaviour at the edges:
  - If `read_req` is still high after a capture, the FSM re-arms only after the key is released. A held key can never produce two captures.
  - If `press` and a `read_req` fall occur in the same cycle, the cancel wins.
  - `reset` mid-operation returns the FSM to IDLE and clears the debouncer. Any pending capture is dropped.
- Reset values: `dadosLidos=0`, `data_valid=0`, `busy=0`, `echo=0`, FSM=IDLE, debounce counter=0.

## Timing
- `busy` rises one cycle after `read_req` is sampled high in IDLE.
- Press-to-strobe latency is 2 (synchronizer) + `DEBOUNCE_CYCLES` + 1 (FSM register) cycles after the pin falls.
- `data_valid` and the new `dadosLidos` appear in the same cycle. `busy` is low in that cycle.
- The switch value captured is the synchronized value present on the cycle the `press` event occurs.
- Counter width is `$clog2(DEBOUNCE_CYCLES)`. The counter never wraps; it clears at the terminal count.

## Configuration
- `INPUT_CAPTURE_ECHO_EN` defined: `echo` is a register that updates to the captured value on every `data_valid`, so the 7-segment path shows the user's last input.
- Undefined: `echo` is tied to 32'b0 and the register is not built.

## Structure
- Shared IO package:
  - FSM state enum `{IDLE, ARMED, RELEASE}`.
  - Constants `SW_WIDTH=18` and `SIGN_BIT=17`.
  - A default `DEBOUNCE_CYCLES` value.
- One sub-module, `key_debounce`: synchronizer, counter and `key_stable` for a single key, with a `press` pulse output. It is reusable for further pushbuttons.
- The switch synchronizer and the FSM stay in the top module.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- Reset, then idle: all outputs are 0, and `busy=0` with `read_req=0`.
- `dadosExternos=18'h00005`, `read_req=1`, press held for 10 cycles → `busy` rises the next cycle. 7 cycles after the press, `data_valid` pulses once with `dadosLidos=32'h00000005`, then `busy=0`.
- `dadosExternos=18'h20003`, one capture → `dadosLidos=32'hFFFE0003`. The strobe is exactly one cycle wide.
- Bounce: toggle `confirm_n` every 2 cycles for 12 cycles while ARMED → no strobe. A steady press afterwards captures exactly once.
- Key held and `read_req` kept high across the capture → a single strobe only. After release plus debounce, `busy` reasserts, and a new press gives a second capture.
- `read_req` dropped while ARMED → FSM returns to IDLE with no strobe. `reset` asserted mid-debounce → all outputs return to reset values the next cycle. With `INPUT_CAPTURE_ECHO_EN` defined, `echo` tracks every capture; without it, `echo` stays 0.

Source files
------------

// File: rtl/user_input_capture_pkg.sv
// Shared definitions for the user input capture block: FSM states, switch
// geometry, default debounce length and the switch sign-extension helper.
package user_input_capture_pkg;

  localparam int unsigned SW_WIDTH                = 18;
  localparam int unsigned SIGN_BIT                = 17;
  localparam int unsigned DATA_WIDTH              = 32;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 50000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } capture_state_t;

  // Replicates the switch sign bit across the upper word, keeping the low 17 bits.
  function automatic logic [DATA_WIDTH-1:0] sign_extend_sw(input logic [SW_WIDTH-1:0] sw);
    return {{(DATA_WIDTH - SIGN_BIT){sw[SIGN_BIT]}}, sw[SIGN_BIT-1:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioner: 2-flop synchronizer, stability counter and a
// registered press pulse on every accepted 0->1 change of the key.
// The key input is active-high; invert active-low buttons before this block.
module key_debounce
  import user_input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_raw,
  output logic key_stable,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             key_sync;

  assign key_sync = sync_q[1];

  // Synchronizer, counter, stable level and press pulse registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      press_q  <= press_d;
    end
  end

  // Accept a change only after the synchronized key differs for DEBOUNCE_CYCLES cycles.
  always_comb begin
    sync_d   = {sync_q[0], key_raw};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (key_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
      press_d  = ~stable_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign key_stable = stable_q;
  assign press      = press_q;

endmodule

// File: rtl/user_input_capture.sv
// User input capture: stalls a CPU read until the confirm button is pressed,
// then latches the sign-extended switches with a one-cycle valid strobe.
// Optional feature macro: INPUT_CAPTURE_ECHO_EN builds the echo register;
// otherwise echo is tied to zero.
module user_input_capture
  import user_input_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [SW_WIDTH-1:0]   dadosExternos,
  input  logic                  confirm_n,
  input  logic                  read_req,
  output logic [DATA_WIDTH-1:0] dadosLidos,
  output logic                  data_valid,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] echo
);

  capture_state_t        state_q, state_d;
  logic [SW_WIDTH-1:0]   sw_meta_q, sw_meta_d;
  logic [SW_WIDTH-1:0]   sw_sync_q, sw_sync_d;
  logic [DATA_WIDTH-1:0] dados_lidos_q, dados_lidos_d;
  logic                  data_valid_q, data_valid_d;
  logic                  busy_q, busy_d;
  logic                  capture_c;
  logic                  confirm_raw;
  logic                  key_stable;
  logic                  press;

  assign confirm_raw = ~confirm_n;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_debounce (
    .clock      (clock),
    .reset      (reset),
    .key_raw    (confirm_raw),
    .key_stable (key_stable),
    .press      (press)
  );

  // State, switch synchronizer and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      sw_meta_q     <= '0;
      sw_sync_q     <= '0;
      dados_lidos_q <= '0;
      data_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sw_meta_q     <= sw_meta_d;
      sw_sync_q     <= sw_sync_d;
      dados_lidos_q <= dados_lidos_d;
      data_valid_q  <= data_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Handshake FSM: arm on request, capture on press, wait for key release.
  always_comb begin
    state_d       = state_q;
    sw_meta_d     = dadosExternos;
    sw_sync_d     = sw_meta_q;
    dados_lidos_d = dados_lidos_q;
    data_valid_d  = 1'b0;
    capture_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (read_req) state_d = ARMED;
      end
      ARMED: begin
        // A request drop beats a simultaneous press.
        if (!read_req) begin
          state_d = IDLE;
        end else if (press) begin
          capture_c = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: begin
        if (!key_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture_c) begin
      dados_lidos_d = sign_extend_sw(sw_sync_q);
      data_valid_d  = 1'b1;
    end

    busy_d = (state_d == ARMED);
  end

  assign dadosLidos = dados_lidos_q;
  assign data_valid = data_valid_q;
  assign busy       = busy_q;

`ifdef INPUT_CAPTURE_ECHO_EN
  logic [DATA_WIDTH-1:0] echo_q, echo_d;

  // Echo register for the 7-segment path.
  always_ff @(posedge clock) begin
    if (reset) echo_q <= '0;
    else       echo_q <= echo_d;
  end

  // Follow every capture in the same cycle as dadosLidos.
  always_comb begin
    echo_d = echo_q;
    if (capture_c) echo_d = dados_lidos_d;
  end

  assign echo = echo_q;
`else
  assign echo = '0;
`endif

endmodule

// File: tb/tb_user_input_capture.sv
// Directed bench for user_input_capture with DEBOUNCE_CYCLES=4.
module tb_user_input_capture;

  localparam int unsigned DC = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [17:0] dadosExternos;
  logic        confirm_n;
  logic        read_req;
  logic [31:0] dadosLidos;
  logic        data_valid;
  logic        busy;
  logic [31:0] echo;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  user_input_capture #(
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dadosExternos (dadosExternos),
    .confirm_n     (confirm_n),
    .read_req      (read_req),
    .dadosLidos    (dadosLidos),
    .data_valid    (data_valid),
    .busy          (busy),
    .echo          (echo)
  );

  typedef struct {
    logic        rst;
    logic [17:0] sw;
    logic        cn;
    logic        rr;
    logic        exp_valid;
    logic        exp_busy;
    logic [31:0] exp_dados;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] exp_echo(input logic [31:0] d);
`ifdef INPUT_CAPTURE_ECHO_EN
    return d;
`else
    return 32'h0 & d;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [17:0] sw, input logic cn, input logic rr,
                     input logic ev, input logic eb, input logic [31:0] ed);
    vec_t v;
    v.rst = rst; v.sw = sw; v.cn = cn; v.rr = rr;
    v.exp_valid = ev; v.exp_busy = eb; v.exp_dados = ed;
    vecs.push_back(v);
  endtask

  // Request plus press held 10 cycles, then release and settle back to IDLE.
  task automatic add_capture(input logic [17:0] sw, input logic [31:0] prev, input logic [31:0] nxt);
    for (int i = 1; i <= 6; i++) add(1'b0, sw, 1'b0, 1'b1, 1'b0, 1'b1, prev);
    add(1'b0, sw, 1'b0, 1'b1, 1'b1, 1'b0, nxt);
    for (int i = 8; i <= 10; i++) add(1'b0, sw, 1'b0, 1'b0, 1'b0, 1'b0, nxt);
    for (int i = 11; i <= 20; i++) add(1'b0, sw, 1'b1, 1'b0, 1'b0, 1'b0, nxt);
  endtask

  task automatic drive(input logic rst, input logic [17:0] sw, input logic cn, input logic rr);
    reset = rst; dadosExternos = sw; confirm_n = cn; read_req = rr;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          nv;
    int          lat;
    logic [31:0] cap;

    drive(1'b1, 18'h0, 1'b1, 1'b0);

    // Reset and idle rows.
    add(1'b1, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b1, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    add(1'b0, 18'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Press while IDLE is discarded.
    for (int i = 0; i < 10; i++) add(1'b0, 18'h00005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) add(1'b0, 18'h00005, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    // Positive and negative captures.
    add_capture(18'h00005, 32'h0, 32'h00000005);
    add_capture(18'h20003, 32'h00000005, 32'hFFFE0003);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].sw, vecs[i].cn, vecs[i].rr);
      step();
      check($sformatf("vec%0d data_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d dadosLidos", i), dadosLidos, vecs[i].exp_dados);
      check($sformatf("vec%0d echo", i), echo, exp_echo(vecs[i].exp_dados));
    end

    // Bounce while ARMED gives no strobe; a steady press then captures once.
    drive(1'b0, 18'h1FFFF, 1'b1, 1'b1);
    step();
    check("bounce armed busy", 32'(busy), 32'd1);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      confirm_n = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      step();
      nv += int'(data_valid);
    end
    for (int i = 0; i < 4; i++) begin
      confirm_n = 1'b1;
      step();
      nv += int'(data_valid);
    end
    check("bounce no strobe", 32'(nv), 32'd0);
    check("bounce still busy", 32'(busy), 32'd1);
    confirm_n = 1'b0;
    nv = 0; lat = 0; cap = 32'h0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (data_valid) begin
        nv++;
        lat = i;
        cap = dadosLidos;
      end
    end
    check("steady press strobe count", 32'(nv), 32'd1);
    check("steady press latency", 32'(lat), 32'd7);
    check("steady press dadosLidos", cap, 32'h0001FFFF);
    check("steady press echo", echo, exp_echo(32'h0001FFFF));

    // Held key with read_req high: no second capture until release.
    check("held key busy low", 32'(busy), 32'd0);
    confirm_n = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      nv += int'(data_valid);
      if (busy && lat == 0) lat = i;
    end
    check("held key single strobe", 32'(nv), 32'd1);
    check("rearm latency after release", 32'(lat), 32'd8);
    dadosExternos = 18'h3FFFF;
    confirm_n = 1'b0;
    nv = 0; cap = 32'h0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_valid) begin
        nv++;
        cap = dadosLidos;
      end
    end
    check("second capture count", 32'(nv), 32'd1);
    check("second capture dadosLidos", cap, 32'hFFFFFFFF);
    drive(1'b0, 18'h3FFFF, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step();

    // read_req falls on the press cycle: cancel wins.
    drive(1'b0, 18'h00AAA, 1'b1, 1'b1);
    step();
    check("cancel armed busy", 32'(busy), 32'd1);
    confirm_n = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("cancel pre busy", 32'(busy), 32'd1);
    read_req = 1'b0;
    step();
    check("cancel data_valid", 32'(data_valid), 32'd0);
    check("cancel busy", 32'(busy), 32'd0);
    check("cancel dadosLidos kept", dadosLidos, 32'hFFFFFFFF);
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      nv += int'(data_valid);
    end
    confirm_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      nv += int'(data_valid);
    end
    check("cancel no strobe", 32'(nv), 32'd0);

    // Reset mid-debounce.
    drive(1'b0, 18'h00005, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    check("mid debounce busy", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    check("reset dadosLidos", dadosLidos, 32'h0);
    check("reset data_valid", 32'(data_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset echo", echo, 32'h0);
    drive(1'b0, 18'h00005, 1'b1, 1'b0);
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      nv += int'(data_valid);
    end
    check("post reset no strobe", 32'(nv), 32'd0);
    check("post reset dadosLidos", dadosLidos, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
